stage_sequencer: RTL

Multi-cycle control FSM for the TP2 RV32I core. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and issues per-stage enables and memory requests. It also drives the write port of `register_bank` (write enable, destination index, writeback-source select). It sits between the instruction decoder, the instruction/data memories and the register bank, and replaces the free-running `stage_clk` stepping with handshaked sequencing.

---
 rtl/stage_sequencer_if.sv | 34 +++
 rtl/stage_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer_if.sv
// Memory handshake and register-bank write port between stage_sequencer and its neighbours.
// master: the sequencer side; slave: the memories / register bank side.
interface stage_sequencer_if;
    logic       imem_req;
    logic       imem_ready;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ready;
    logic       rf_we;
    logic [4:0] rf_rd;
    logic       wb_sel;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        output rf_we,
        output rf_rd,
        output wb_sel,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        input  rf_we,
        input  rf_rd,
        input  wb_sel,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the TP2 RV32I core.
// Optional STAGE_SEQ_TIMEOUT_EN adds a wait-cycle watchdog on FETCH and MEM.
module stage_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                     stage_clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     is_load,
    input  logic                     is_store,
    input  logic                     reg_write,
    input  logic [4:0]               rd,
    stage_sequencer_if.master        bus,
    output logic                     fetch_en,
    output logic                     decode_en,
    output logic                     exec_en,
    output logic                     mem_en,
    output logic                     wb_en,
    output logic                     pc_en,
    output logic                     busy,
    output logic                     fault,
    output logic [31:0]              instr_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        load_r;
    logic        store_r;
    logic        write_r;
    logic [4:0]  rd_r;
    logic [31:0] count_r;
    logic        timeout_s;

    if ((MEM_TIMEOUT < 1) || (MEM_TIMEOUT > 255)) begin : g_bad_timeout
        $error("stage_sequencer: MEM_TIMEOUT must be in 1..255");
    end

`ifdef STAGE_SEQ_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    logic [7:0] wait_cnt_r;
    logic       waiting_s;

    // Flags a cycle spent in FETCH or MEM with the relevant ready low.
    always_comb begin
        waiting_s = 1'b0;
        if (state_r == ST_FETCH) begin
            waiting_s = ~bus.imem_ready;
        end else if (state_r == ST_MEM) begin
            waiting_s = ~bus.dmem_ready;
        end else begin
            waiting_s = 1'b0;
        end
    end

    // Limit reached with ready still low; a ready in that same cycle wins.
    assign timeout_s = waiting_s & (wait_cnt_r >= TIMEOUT_LIMIT);

    // Counts consecutive not-ready cycles; any other cycle clears it, so it restarts on entry.
    always_ff @(posedge stage_clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= 8'd0;
        end else if (waiting_s && !timeout_s) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= 8'd0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge stage_clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; decode flags are checked raw here because the latches update on this edge.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    next_state_s = ST_DECODE;
                end else if (timeout_s) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (is_load && is_store) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (load_r || store_r) begin
                    next_state_s = ST_MEM;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (bus.dmem_ready) begin
                    next_state_s = ST_WB;
                end else if (timeout_s) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_WB: begin
                if (run) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FAULT: begin
                next_state_s = ST_FAULT;
            end
            default: begin
                next_state_s = ST_FAULT;
            end
        endcase
    end

    // Decoder flags captured once per instruction, held until the next DECODE.
    always_ff @(posedge stage_clk or posedge reset) begin
        if (reset) begin
            load_r  <= 1'b0;
            store_r <= 1'b0;
            write_r <= 1'b0;
            rd_r    <= 5'd0;
        end else if (state_r == ST_DECODE) begin
            load_r  <= is_load;
            store_r <= is_store;
            write_r <= reg_write;
            rd_r    <= rd;
        end else begin
            load_r  <= load_r;
            store_r <= store_r;
            write_r <= write_r;
            rd_r    <= rd_r;
        end
    end

    // Retired-instruction counter, bumped on the edge that ends WB.
    always_ff @(posedge stage_clk or posedge reset) begin
        if (reset) begin
            count_r <= 32'd0;
        end else if (state_r == ST_WB) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Moore output decode from the state register and the DECODE latches.
    always_comb begin
        fetch_en     = 1'b0;
        decode_en    = 1'b0;
        exec_en      = 1'b0;
        mem_en       = 1'b0;
        wb_en        = 1'b0;
        pc_en        = 1'b0;
        busy         = 1'b1;
        fault        = 1'b0;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.rf_we    = 1'b0;
        bus.wb_sel   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_FETCH: begin
                fetch_en     = 1'b1;
                bus.imem_req = 1'b1;
            end
            ST_DECODE: begin
                decode_en = 1'b1;
            end
            ST_EXEC: begin
                exec_en = 1'b1;
            end
            ST_MEM: begin
                mem_en       = 1'b1;
                bus.dmem_req = 1'b1;
                bus.dmem_we  = store_r;
            end
            ST_WB: begin
                wb_en      = 1'b1;
                pc_en      = 1'b1;
                bus.wb_sel = load_r;
                // x0 is hardwired to zero, so a write to it is never issued.
                bus.rf_we  = write_r & (rd_r != 5'd0);
            end
            ST_FAULT: begin
                busy  = 1'b0;
                fault = 1'b1;
            end
            default: begin
                busy  = 1'b0;
                fault = 1'b1;
            end
        endcase
    end

    assign bus.rf_rd   = rd_r;
    assign instr_count = count_r;

endmodule
